// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding and default word width.
package serial_deserializer_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int STATE_W       = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_DATA    = 3'd1,
      ST_PARITY  = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } state_e;

endpackage

// File: rtl/serial_deserializer_out_reg.sv
// Single-entry valid/ready holding register for assembled words; flags overrun when a
// completed word arrives while the held word is still waiting for the consumer.
module serial_deserializer_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             par_err_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             par_err_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ovr_q, ovr_d;
   logic             accept;

   // A word may load when the slot is empty or is being drained on this same edge.
   assign accept = !valid_q || ready_i;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         perr_d = par_err_i;
         if (accept) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign par_err_o = perr_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver sampling on an external bit strobe.
// Optional even-parity bit and checking enabled by defining PARITY_CHECK_EN.
module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             data_in,
   input  logic             sample_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_error,
   output logic             parity_error,
   output logic             overrun
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] shift_q;
   logic             frame_err_q;
   logic             word_done;
   logic             par_bad;
`ifdef PARITY_CHECK_EN
   logic             par_q;
`endif

   assign word_done = sample_en && (state_q == ST_STOP) && data_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         if (sample_en) begin
            case (state_q)
               ST_IDLE: begin
                  if (!data_in) begin
                     state_q <= ST_DATA;
                     cnt_q   <= '0;
                  end
               end
               ST_DATA: begin
                  shift_q[cnt_q] <= data_in;
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`ifdef PARITY_CHECK_EN
               ST_PARITY: begin
                  par_q   <= data_in;
                  state_q <= ST_STOP;
               end
`endif
               ST_STOP: begin
                  if (data_in) begin
                     state_q <= ST_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_RECOVER;
                  end
               end
               // A line stuck low after a bad stop bit must go high before a new start counts.
               ST_RECOVER: begin
                  if (data_in) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef PARITY_CHECK_EN
   assign par_bad = ^{shift_q, par_q};
`else
   assign par_bad = 1'b0;
`endif

   assign frame_error = frame_err_q;

   serial_deserializer_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clock     (clock),
      .reset     (reset),
      .load_i    (word_done),
      .data_i    (shift_q),
      .par_err_i (par_bad),
      .ready_i   (out_ready),
      .data_o    (out_data),
      .valid_o   (out_valid),
      .par_err_o (parity_error),
      .overrun_o (overrun)
   );

endmodule
